// File: rtl/bomb_pkg.sv
// ============================================================================
// Module   : bomb_pkg
// Purpose  : Shared types, widths and the code-digit selector for bomb_judge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bomb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WIN   = 2'd2,
        FAIL  = 2'd3
    } bomb_state_t;

    localparam int KEY_W       = 4;
    localparam int CODE_DIGITS = 4;
    localparam int SECS_W      = 7;
    localparam int IDX_W       = $clog2(CODE_DIGITS);

    // Digit 0 lives in the most significant nibble of the code word.
    function automatic logic [KEY_W-1:0] code_digit(
        input logic [KEY_W*CODE_DIGITS-1:0] code,
        input logic [IDX_W-1:0]             idx
    );
        return code[(CODE_DIGITS - 1 - int'(idx)) * KEY_W +: KEY_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/bomb_tick_gen.sv
// ============================================================================
// Module   : bomb_tick_gen
// Purpose  : Countdown prescaler; emits a one-cycle tick when it wraps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bomb_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bomb_judge.sv
// ============================================================================
// Module   : bomb_judge
// Purpose  : Bomb game controller: countdown, keypad code check, win/fail and
//            fail/repeatRst handshake. Strike counting under BOMB_STRIKES_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bomb_judge
    import bomb_pkg::*;
#(
    parameter int                           TICK_DIV    = 50_000_000,
    parameter int                           TIME_S      = 60,
    parameter logic [KEY_W*CODE_DIGITS-1:0] CODE        = 16'h1234,
    parameter int                           MAX_STRIKES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              key_valid,
    input  logic [KEY_W-1:0]  key_code,
    input  logic              repeatRst,
    output logic              fail,
    output logic              win,
    output logic              armed,
    output logic [SECS_W-1:0] secs_left,
    output logic [IDX_W-1:0]  digit_idx,
    output logic [2:0]        strikes
);

    bomb_state_t       state_q;
    logic              fail_q;
    logic              win_q;
    logic              armed_q;
    logic [SECS_W-1:0] secs_q;
    logic [IDX_W-1:0]  idx_q;

    logic start_acc;
    logic tick;
    logic key_ok;
    logic key_match;
    logic expire;
    logic code_done;
    logic strike_fail;

    assign start_acc = (state_q == IDLE) && start && !repeatRst;
    assign key_ok    = key_valid && (key_code <= KEY_W'(9));
    assign key_match = (key_code == code_digit(CODE, idx_q));
    assign expire    = tick && (secs_q == SECS_W'(1));
    assign code_done = key_ok && key_match && (idx_q == IDX_W'(CODE_DIGITS - 1));

    bomb_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_acc),
        .en   (state_q == ARMED),
        .tick (tick)
    );

`ifdef BOMB_STRIKES_EN
    localparam logic [2:0] MAX_S = 3'(MAX_STRIKES);

    logic [2:0] strikes_q;
    logic [2:0] strikes_d;
    logic       strike_hit;

    // A wrong digit that coincides with expiry is not counted; expiry wins.
    assign strike_hit  = (state_q == ARMED) && key_ok && !key_match && !expire;
    assign strikes_d   = strikes_q + 3'd1;
    assign strike_fail = (strikes_d == MAX_S);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strikes_q <= '0;
        end else if (start_acc) begin
            strikes_q <= '0;
        end else if (strike_hit) begin
            strikes_q <= strikes_d;
        end
    end

    assign strikes = strikes_q;
`else
    logic unused_max_strikes;

    assign unused_max_strikes = ^MAX_STRIKES;
    assign strike_fail        = 1'b1;
    assign strikes            = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            fail_q  <= 1'b0;
            win_q   <= 1'b0;
            armed_q <= 1'b0;
            secs_q  <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_acc) begin
                        state_q <= ARMED;
                        armed_q <= 1'b1;
                        secs_q  <= SECS_W'(TIME_S);
                        idx_q   <= '0;
                    end
                end
                ARMED: begin
                    if (expire) begin
                        state_q <= FAIL;
                        armed_q <= 1'b0;
                        fail_q  <= 1'b1;
                        secs_q  <= '0;
                        idx_q   <= '0;
                    end else if (code_done) begin
                        // The countdown freezes at its pre-tick value on a win.
                        state_q <= WIN;
                        armed_q <= 1'b0;
                        win_q   <= 1'b1;
                        idx_q   <= '0;
                    end else begin
                        if (tick) begin
                            secs_q <= secs_q - SECS_W'(1);
                        end
                        if (key_ok) begin
                            if (key_match) begin
                                idx_q <= idx_q + IDX_W'(1);
                            end else begin
                                idx_q <= '0;
                                if (strike_fail) begin
                                    state_q <= FAIL;
                                    armed_q <= 1'b0;
                                    fail_q  <= 1'b1;
                                end
                            end
                        end
                    end
                end
                WIN: begin
                    if (start) begin
                        state_q <= IDLE;
                        win_q   <= 1'b0;
                    end
                end
                FAIL: begin
                    if (repeatRst) begin
                        state_q <= IDLE;
                        fail_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fail      = fail_q;
    assign win       = win_q;
    assign armed     = armed_q;
    assign secs_left = secs_q;
    assign digit_idx = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_bomb_judge.sv
// ============================================================================
// Module   : tb_bomb_judge
// Purpose  : Scoreboard bench for bomb_judge (TICK_DIV=4, TIME_S=3, code 1234).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bomb_judge;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       key_valid;
    logic [3:0] key_code;
    logic       repeatRst;
    logic       fail;
    logic       win;
    logic       armed;
    logic [6:0] secs_left;
    logic [1:0] digit_idx;
    logic [2:0] strikes;

    bomb_judge #(
        .TICK_DIV    (4),
        .TIME_S      (3),
        .CODE        (16'h1234),
        .MAX_STRIKES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_valid (key_valid),
        .key_code  (key_code),
        .repeatRst (repeatRst),
        .fail      (fail),
        .win       (win),
        .armed     (armed),
        .secs_left (secs_left),
        .digit_idx (digit_idx),
        .strikes   (strikes)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] v;
        logic [14:0] m;
        string       tag;
    } exp_t;

    localparam logic [14:0] FULL    = 15'h7FFF;
    localparam logic [14:0] NO_IDX  = 15'h7FE7;

    exp_t        sb[$];
    exp_t        e;
    int          vectors     = 0;
    int          miscompares = 0;
    logic [14:0] obs;

    assign obs = {fail, win, armed, secs_left, digit_idx, strikes};

    function automatic logic [14:0] E(input logic f, input logic w, input logic a,
                                      input int s, input int i, input int k);
        return {f, w, a, 7'(s), 2'(i), 3'(k)};
    endfunction

    function automatic logic [6:0] S(input logic st, input logic kv,
                                     input int kc, input logic rr);
        return {st, kv, 4'(kc), rr};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        sb.push_back('{E(0, 0, 0, 0, 0, 0), FULL, "reset"});
        e = sb.pop_front();
        vectors++;
        if ((obs & e.m) !== (e.v & e.m)) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.tag, obs, e.v);
        end
        rst = 1'b0;
    endtask

    task automatic test_correct();
        logic [6:0]  st [7];
        logic [14:0] ex [7];
        st = '{S(1,0,0,0), S(0,1,1,0), S(0,1,2,0), S(0,1,3,0), S(0,1,4,0),
               S(0,0,0,0), S(1,0,0,0)};
        ex = '{E(0,0,1,3,0,0), E(0,0,1,3,1,0), E(0,0,1,3,2,0), E(0,0,1,3,3,0),
               E(0,1,0,3,0,0), E(0,1,0,3,0,0), E(0,0,0,3,0,0)};
        for (int k = 0; k < 7; k++) begin
            {start, key_valid, key_code, repeatRst} = st[k];
            sb.push_back('{ex[k], FULL, $sformatf("correct[%0d]", k)});
            step();
            e = sb.pop_front();
            vectors++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.tag, obs, e.v);
            end
        end
        {start, key_valid, key_code, repeatRst} = '0;
    endtask

    task automatic test_timeout();
        logic [14:0] ev;
        for (int k = 0; k < 15; k++) begin
            start     = (k == 0);
            key_valid = 1'b0;
            repeatRst = (k >= 13);
            if (k < 12)       ev = E(0, 0, 1, 3 - k / 4, 0, 0);
            else if (k == 12) ev = E(1, 0, 0, 0, 0, 0);
            else              ev = E(0, 0, 0, 0, 0, 0);
            sb.push_back('{ev, FULL, $sformatf("timeout[%0d]", k)});
            step();
            e = sb.pop_front();
            vectors++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.tag, obs, e.v);
            end
        end
        start = 1'b0;
    endtask

    // Leaves the DUT freshly armed for the wrong-digit scenario.
    task automatic test_stale_handshake();
        logic [6:0]  st [3];
        logic [14:0] ex [3];
        st = '{S(1,0,0,1), S(0,0,0,0), S(1,0,0,0)};
        ex = '{E(0,0,0,0,0,0), E(0,0,0,0,0,0), E(0,0,1,3,0,0)};
        for (int k = 0; k < 3; k++) begin
            {start, key_valid, key_code, repeatRst} = st[k];
            sb.push_back('{ex[k], FULL, $sformatf("stale[%0d]", k)});
            step();
            e = sb.pop_front();
            vectors++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.tag, obs, e.v);
            end
        end
        {start, key_valid, key_code, repeatRst} = '0;
    endtask

    task automatic test_wrong_digit();
        logic [6:0]  st [5];
        logic [14:0] ex [5];
`ifdef BOMB_STRIKES_EN
        st = '{S(0,1,9,0), S(0,1,9,0), S(0,1,9,0), S(0,0,0,1), S(0,0,0,0)};
        ex = '{E(0,0,1,3,0,1), E(0,0,1,3,0,2), E(1,0,0,3,0,3), E(0,0,0,3,0,3),
               E(0,0,0,3,0,3)};
`else
        st = '{S(0,1,1,0), S(0,1,5,0), S(0,0,0,0), S(0,0,0,1), S(0,0,0,0)};
        ex = '{E(0,0,1,3,1,0), E(1,0,0,3,0,0), E(1,0,0,3,0,0), E(0,0,0,3,0,0),
               E(0,0,0,3,0,0)};
`endif
        for (int k = 0; k < 5; k++) begin
            {start, key_valid, key_code, repeatRst} = st[k];
            sb.push_back('{ex[k], FULL, $sformatf("wrong[%0d]", k)});
            step();
            e = sb.pop_front();
            vectors++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.tag, obs, e.v);
            end
        end
        {start, key_valid, key_code, repeatRst} = '0;
    endtask

    // Keys 1,2,3 late in the countdown, key 4 on the expiring tick; key 10 ignored.
    task automatic test_collision();
        logic [14:0] ev;
        logic [14:0] mk;
        for (int k = 0; k < 15; k++) begin
            start     = (k == 0);
            key_valid = (k == 1) || (k >= 9 && k <= 12);
            key_code  = (k == 1) ? 4'd10 : 4'(k - 8);
            repeatRst = (k >= 13);
            mk        = FULL;
            if (k < 12) begin
                ev = E(0, 0, 1, 3 - k / 4, (k >= 9) ? k - 8 : 0, 0);
            end else if (k == 12) begin
                ev = E(1, 0, 0, 0, 0, 0);
                mk = NO_IDX;
            end else begin
                ev = E(0, 0, 0, 0, 0, 0);
                mk = NO_IDX;
            end
            sb.push_back('{ev, mk, $sformatf("collision[%0d]", k)});
            step();
            e = sb.pop_front();
            vectors++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.tag, obs, e.v);
            end
        end
        {start, key_valid, key_code, repeatRst} = '0;
    endtask

    task automatic test_reset_mid();
        logic [6:0]  st [3];
        logic [14:0] ex [3];
        st = '{S(1,0,0,0), S(0,1,1,0), S(0,1,2,0)};
        ex = '{E(0,0,1,3,0,0), E(0,0,1,3,1,0), E(0,0,1,3,2,0)};
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                {start, key_valid, key_code, repeatRst} = st[k];
                sb.push_back('{ex[k], FULL, $sformatf("rstmid[%0d]", k)});
                step();
            end else if (k == 3) begin
                {start, key_valid, key_code, repeatRst} = '0;
                rst = 1'b1;
                sb.push_back('{E(0,0,0,0,0,0), FULL, "rstmid_async"});
                #1;
            end else begin
                rst = 1'b0;
                sb.push_back('{E(0,0,0,0,0,0), FULL, "rstmid_after"});
                step();
            end
            e = sb.pop_front();
            vectors++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.tag, obs, e.v);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'd0;
        repeatRst = 1'b0;
        test_reset();
        test_correct();
        test_timeout();
        test_stale_handshake();
        test_wrong_digit();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
